count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker_pkg.sv | 14 +
 rtl/count_checker_sat_counter.sv | 21 ++
 rtl/count_checker.sv | 151 +++++++++++++++
 tb/tb_count_checker.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// count_checker shared types and widths.
// Imported by count_checker and sat_counter.
package count_checker_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/count_checker_sat_counter.sv
// sat_counter: synchronous saturating incrementer.
// Holds at all-ones instead of wrapping.
module sat_counter
  import count_checker_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // count up on inc, stick at the top value
  always_ff @(posedge clk) begin
    if (res) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/count_checker.sv
// count_checker: lock/track an incrementing byte stream.
// COUNT_CHECKER_ERRCNT_EN enables the errcnt counter.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              stop,
  input  logic              vin,
  input  logic [DATA_W-1:0] datain,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  errcnt
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] expd;
  logic [DATA_W-1:0] expd_nx;
  logic [3:0]        run;
  logic [3:0]        run_nx;
  logic [3:0]        bad;
  logic [3:0]        bad_nx;
  logic [3:0]        run_inc;
  logic [3:0]        bad_inc;
  logic              acc;
  logic              hit;
  logic              is_hunt;
  logic              is_sync;
  logic              is_lock;
  logic              err_nx;
  logic              locked_nx;

  assign acc     = vin & ~stop;
  assign hit     = (datain == expd);
  assign run_inc = run + 4'd1;
  assign bad_inc = bad + 4'd1;
  assign is_hunt = (state == HUNT);
  assign is_sync = (state == SYNC);
  assign is_lock = (state == LOCKED);

  // state register
  always_ff @(posedge clk) begin
    if (res) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // next-state: only accepted samples move the FSM
  always_comb begin
    state_nx = state;
    if (acc) begin
      unique case (state)
        HUNT:   state_nx = SYNC;
        SYNC: begin
          if (hit && (run_inc == LOCK_N))
            state_nx = LOCKED;
        end
        LOCKED: begin
          if (!hit && (bad_inc == UNLOCK_N))
            state_nx = HUNT;
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // expected / run / bad updates for an accepted sample
  always_comb begin
    expd_nx = expd;
    run_nx  = run;
    bad_nx  = bad;
    if (acc) begin
      unique case (1'b1)
        is_hunt: begin
          expd_nx = datain + 8'd1;
          run_nx  = 4'd1;
          bad_nx  = '0;
        end
        is_sync && hit: begin
          expd_nx = expd + 8'd1;
          run_nx  = run_inc;
          bad_nx  = '0;
        end
        is_sync && !hit: begin
          expd_nx = datain + 8'd1;
          run_nx  = 4'd1;
        end
        is_lock && hit: begin
          expd_nx = expd + 8'd1;
          bad_nx  = '0;
        end
        is_lock && !hit: begin
          expd_nx = datain + 8'd1;
          if (bad_inc == UNLOCK_N) begin
            bad_nx = '0;
            run_nx = '0;
          end else begin
            bad_nx = bad_inc;
          end
        end
        default: begin
          expd_nx = expd;
        end
      endcase
    end
  end

  // output decode, registered below
  always_comb begin
    err_nx    = acc & is_lock & ~hit;
    locked_nx = (state_nx == LOCKED);
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (res) begin
      expd   <= '0;
      run    <= '0;
      bad    <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      expd   <= expd_nx;
      run    <= run_nx;
      bad    <= bad_nx;
      locked <= locked_nx;
      err    <= err_nx;
    end
  end

`ifdef COUNT_CHECKER_ERRCNT_EN
  sat_counter u_errcnt (
    .clk (clk),
    .res (res),
    .inc (err_nx),
    .q   (errcnt)
  );
`else
  assign errcnt = '0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: scoreboard bench for count_checker.
// Model predicts locked/err/errcnt per accepted edge.
module tb_count_checker;

`ifdef COUNT_CHECKER_ERRCNT_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        stop = 1'b0;
  logic        vin = 1'b0;
  logic [7:0]  datain = 8'h00;
  logic        locked;
  logic        err;
  logic [15:0] errcnt;

  count_checker dut (
    .clk    (clk),
    .res    (res),
    .stop   (stop),
    .vin    (vin),
    .datain (datain),
    .locked (locked),
    .err    (err),
    .errcnt (errcnt)
  );

`ifdef COUNT_CHECKER_ERRCNT_EN
  logic        s_res = 1'b1;
  logic        s_stop = 1'b0;
  logic        s_vin = 1'b0;
  logic [7:0]  s_dat = 8'h00;
  logic        s_locked;
  logic        s_err;
  logic [15:0] s_errcnt;

  count_checker #(
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (15)
  ) u_sat (
    .clk    (clk),
    .res    (s_res),
    .stop   (s_stop),
    .vin    (s_vin),
    .datain (s_dat),
    .locked (s_locked),
    .err    (s_err),
    .errcnt (s_errcnt)
  );
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h",
                  tag, got, exp);
  endtask

  typedef struct packed {
    logic        lk;
    logic        er;
    logic [15:0] cnt;
  } sb_t;

  sb_t sbq[$];

  int m_st  = 0;
  int m_exp = 0;
  int m_run = 0;
  int m_bad = 0;
  int m_cnt = 0;

  task automatic model(input bit r, input bit s,
                       input bit v, input int d);
    bit   e;
    sb_t  x;
    e = 1'b0;
    if (r) begin
      m_st = 0; m_exp = 0; m_run = 0;
      m_bad = 0; m_cnt = 0;
    end else if (v && !s) begin
      if (m_st == 0) begin
        m_exp = (d + 1) % 256;
        m_run = 1;
        m_st  = 1;
      end else if (m_st == 1) begin
        if (d == m_exp) begin
          m_exp = (m_exp + 1) % 256;
          m_run = m_run + 1;
          if (m_run == 4) begin
            m_st = 2;
            m_bad = 0;
          end
        end else begin
          m_exp = (d + 1) % 256;
          m_run = 1;
        end
      end else begin
        if (d == m_exp) begin
          m_exp = (m_exp + 1) % 256;
          m_bad = 0;
        end else begin
          e = 1'b1;
          if (EN == 1 && m_cnt < 65535)
            m_cnt = m_cnt + 1;
          m_exp = (d + 1) % 256;
          m_bad = m_bad + 1;
          if (m_bad == 3) begin
            m_st = 0;
            m_bad = 0;
            m_run = 0;
          end
        end
      end
    end
    x.lk  = (m_st == 2);
    x.er  = e;
    x.cnt = 16'(m_cnt);
    sbq.push_back(x);
  endtask

  task automatic step(input bit r, input bit s,
                      input bit v,
                      input logic [7:0] d);
    sb_t x;
    res = r; stop = s; vin = v; datain = d;
    @(posedge clk);
    model(r, s, v, int'(d));
    #1;
    x = sbq.pop_front();
    chk("sb.locked", 32'(locked), 32'(x.lk));
    chk("sb.err", 32'(err), 32'(x.er));
    chk("sb.errcnt", 32'(errcnt), 32'(x.cnt));
  endtask

  task automatic samp(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic rst();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic lock_to(input logic [7:0] last);
    samp(last - 8'd3);
    samp(last - 8'd2);
    samp(last - 8'd1);
    samp(last);
  endtask

`ifdef COUNT_CHECKER_ERRCNT_EN
  task automatic s_step(input bit r,
                        input logic [7:0] d);
    s_res = r; s_vin = 1'b1; s_dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sat_run();
    logic [7:0] k;
    s_step(1'b1, 8'h00);
    s_step(1'b0, 8'h00);
    s_step(1'b0, 8'h01);
    s_step(1'b0, 8'h02);
    s_step(1'b0, 8'h03);
    chk("sat.lock", 32'(s_locked), 32'd1);
    k = 8'h80;
    for (int n = 0; n < 4682; n++) begin
      for (int j = 0; j < 14; j++)
        s_step(1'b0, k);
      if (n == 0) begin
        chk("sat.cnt14", 32'(s_errcnt), 32'd14);
        chk("sat.err14", 32'(s_err), 32'd1);
        chk("sat.lk14", 32'(s_locked), 32'd1);
      end
      k = k + 8'd1;
      s_step(1'b0, k);
    end
    chk("sat.full", 32'(s_errcnt), 32'hFFFF);
    chk("sat.lkend", 32'(s_locked), 32'd1);
    s_vin = 1'b0;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running exp done");
    $fatal(1);
  end

  initial begin
    rst();
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.errcnt", 32'(errcnt), 32'd0);

    samp(8'h10);
    samp(8'h11);
    samp(8'h12);
    chk("lock.pre", 32'(locked), 32'd0);
    samp(8'h13);
    chk("lock.up", 32'(locked), 32'd1);
    chk("lock.err", 32'(err), 32'd0);

    rst();
    lock_to(8'hFD);
    samp(8'hFE);
    samp(8'hFF);
    samp(8'h00);
    chk("wrap.err", 32'(err), 32'd0);
    samp(8'h01);
    chk("wrap.lk", 32'(locked), 32'd1);
    chk("wrap.err2", 32'(err), 32'd0);

    rst();
    lock_to(8'h20);
    samp(8'h21);
    chk("one.pre", 32'(err), 32'd0);
    samp(8'h55);
    chk("one.err", 32'(err), 32'd1);
    chk("one.cnt", 32'(errcnt), 32'(EN));
    chk("one.lk", 32'(locked), 32'd1);
    samp(8'h56);
    chk("one.post", 32'(err), 32'd0);
    chk("one.lk2", 32'(locked), 32'd1);

    rst();
    lock_to(8'h20);
    samp(8'h00);
    chk("ul.e1", 32'(err), 32'd1);
    chk("ul.l1", 32'(locked), 32'd1);
    samp(8'h40);
    chk("ul.e2", 32'(err), 32'd1);
    samp(8'h80);
    chk("ul.e3", 32'(err), 32'd1);
    chk("ul.l3", 32'(locked), 32'd0);
    chk("ul.cnt", 32'(errcnt), 32'(3 * EN));
    samp(8'h81);
    chk("ul.hunt", 32'(err), 32'd0);
    samp(8'h82);
    samp(8'h83);
    samp(8'h84);
    chk("ul.relk", 32'(locked), 32'd1);

    rst();
    lock_to(8'h30);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'hAA);
      chk("stop.err", 32'(err), 32'd0);
    end
    samp(8'h31);
    chk("stop.res", 32'(err), 32'd0);
    chk("stop.lk", 32'(locked), 32'd1);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    chk("rv.lk", 32'(locked), 32'd0);
    chk("rv.err", 32'(err), 32'd0);
    chk("rv.cnt", 32'(errcnt), 32'd0);

    lock_to(8'h43);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0,
           8'($urandom_range(0, 255)));
    chk("idle.lk", 32'(locked), 32'd1);
    samp(8'h44);
    chk("idle.err", 32'(err), 32'd0);

    rst();
    samp(8'h10);
    samp(8'h11);
    step(1'b0, 1'b0, 1'b0, 8'h99);
    samp(8'h12);
    samp(8'h13);
    chk("sync.hold", 32'(locked), 32'd1);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] d;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) != 0)
        d = 8'(m_exp);
      else
        d = 8'($urandom_range(0, 255));
      step(r < 2, r >= 2 && r < 10,
           r < 85, d);
    end

`ifdef COUNT_CHECKER_ERRCNT_EN
    sat_run();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
